// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared definitions for the PS/2 keyboard path: host-transmit
//                FSM state encodings, transmit error codes, common command
//                bytes and a parity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

  // Width of the inhibit/start and transfer timeout counters.
  localparam int unsigned TMR_W = 20;

  // Host transmit FSM encodings.
  localparam int unsigned ST_W = 3;
  typedef logic [ST_W-1:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE    = 3'd0;
  localparam ps2_state_t ST_INHIBIT = 3'd1;
  localparam ps2_state_t ST_REQ     = 3'd2;
  localparam ps2_state_t ST_BITS    = 3'd3;
  localparam ps2_state_t ST_ACK     = 3'd4;
  localparam ps2_state_t ST_RELEASE = 3'd5;
  localparam ps2_state_t ST_DONE    = 3'd6;
  localparam ps2_state_t ST_ERR     = 3'd7;

  // Transmit error codes reported on err_code.
  typedef logic [1:0] ps2_err_t;

  localparam ps2_err_t ERR_NONE     = 2'b00;
  localparam ps2_err_t ERR_START_TO = 2'b01;
  localparam ps2_err_t ERR_NO_ACK   = 2'b10;
  localparam ps2_err_t ERR_XFER_TO  = 2'b11;

  // Frequently used keyboard commands and the device acknowledge byte.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_sync
//  Description : Multi-stage synchronizer for the PS/2 clock and data lines
//                plus a single-cycle falling-edge pulse on the synced clock.
//                Shared by the host transmitter and the receiver.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk         in   system clock
//    rst_n       in   asynchronous active-low reset
//    i_ps2_clk   in   raw PS/2 clock line
//    i_ps2_dat   in   raw PS/2 data line
//    o_clk_sync  out  synchronized clock line
//    o_dat_sync  out  synchronized data line (same latency as o_clk_sync)
//    o_clk_fall  out  1-cycle pulse on synced clock 1->0
// ============================================================================
module ps2_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_clk_sync,
  output logic o_dat_sync,
  output logic o_clk_fall
);

  logic [SYNC_STAGES-1:0] r_clk_chain;
  logic [SYNC_STAGES-1:0] r_dat_chain;
  logic                   r_clk_prev;

  // Both lines idle high (pull-ups), so the chains reset to 1 to avoid a
  // spurious falling edge straight out of reset.
  if (SYNC_STAGES > 1) begin : g_chain
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_clk_chain <= '1;
        r_dat_chain <= '1;
      end else begin
        r_clk_chain <= {r_clk_chain[SYNC_STAGES-2:0], i_ps2_clk};
        r_dat_chain <= {r_dat_chain[SYNC_STAGES-2:0], i_ps2_dat};
      end
    end
  end else begin : g_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_clk_chain <= '1;
        r_dat_chain <= '1;
      end else begin
        r_clk_chain <= i_ps2_clk;
        r_dat_chain <= i_ps2_dat;
      end
    end
  end

  assign o_clk_sync = r_clk_chain[SYNC_STAGES-1];
  assign o_dat_sync = r_dat_chain[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_prev <= o_clk_sync;
    end
  end

  assign o_clk_fall = r_clk_prev & ~o_clk_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device transmitter. Sends one command byte over
//                the open-drain PS2_CLK/PS2_DAT lines, checks the device ACK
//                and reports done or error with a cause code.
//  Revision    : 1.0  initial release
//
//  Ports
//    CLOCK_50   in     system clock, all logic on posedge
//    reset      in     asynchronous active-low reset
//    cmd_data   in     byte to send, captured on cmd_valid && cmd_ready
//    cmd_valid  in     request to send cmd_data
//    cmd_ready  out    high only when idle
//    busy       out    high whenever not idle (gates the receiver)
//    done       out    1-cycle pulse: byte sent, ACKed, lines released
//    error      out    1-cycle pulse: transfer aborted
//    err_code   out    01 start timeout, 10 no ACK, 11 transfer timeout;
//                      held until the next accepted command
//    PS2_CLK    inout  open-drain clock, driven 0 or released
//    PS2_DAT    inout  open-drain data, driven 0 or released
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned XFER_TIMEOUT   = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  // Terminal counts are compared as "count reached N-1", so each phase
  // lasts exactly N cycles measured from state entry.
  localparam logic [TMR_W-1:0] c_inh_last  = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_start_end = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] c_xfer_end  = TMR_W'(XFER_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] c_tmr_max   = '1;
  localparam logic [TMR_W-1:0] c_tmr_one   = TMR_W'(1);
  // Frame index of the parity bit; the edge seen while parity is on the
  // wire puts the stop bit out and hands over to the ACK phase.
  localparam logic [3:0]       c_parity_idx = 4'd8;

  ps2_state_t       r_state;
  ps2_state_t       w_state_next;
  ps2_err_t         w_err_next;
  ps2_err_t         r_err_code;

  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] r_xfer;
  logic [9:0]       r_frame;
  logic [3:0]       r_bit;
  logic             r_dat_low;

  logic             w_clk_sync;
  logic             w_dat_sync;
  logic             w_clk_fall;
  logic             w_accept;
  logic             w_inh_last;
  logic             w_start_to;
  logic             w_xfer_to;
  logic             w_in_xfer;
  logic             w_first_edge;
  logic             w_shift;
  logic             w_clk_low;
  logic             w_dat_low;

  // --------------------------------------------------------------------------
  // Line synchronizer
  // --------------------------------------------------------------------------
  ps2_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (CLOCK_50),
    .rst_n      (reset),
    .i_ps2_clk  (PS2_CLK),
    .i_ps2_dat  (PS2_DAT),
    .o_clk_sync (w_clk_sync),
    .o_dat_sync (w_dat_sync),
    .o_clk_fall (w_clk_fall)
  );

  // --------------------------------------------------------------------------
  // Condition decode
  // --------------------------------------------------------------------------
  assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
  assign w_inh_last = (r_tmr >= c_inh_last);
  assign w_start_to = (r_tmr >= c_start_end);
  assign w_xfer_to  = (r_xfer >= c_xfer_end);
  assign w_in_xfer  = (r_state == ST_BITS) || (r_state == ST_ACK) ||
                      (r_state == ST_RELEASE);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Timeouts are tested before edges so a timeout that
  // coincides with a clock edge always wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_err_next   = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_next = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (w_inh_last) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_start_to) begin
          w_state_next = ST_ERR;
          w_err_next   = ERR_START_TO;
        end else if (w_clk_fall) begin
          w_state_next = ST_BITS;
        end
      end
      ST_BITS: begin
        if (w_xfer_to) begin
          w_state_next = ST_ERR;
          w_err_next   = ERR_XFER_TO;
        end else if (w_clk_fall && (r_bit == c_parity_idx)) begin
          w_state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        // The device pulls DAT low ahead of the eleventh falling edge; the
        // level seen at that edge decides between ACK and no-ACK.
        if (w_xfer_to) begin
          w_state_next = ST_ERR;
          w_err_next   = ERR_XFER_TO;
        end else if (w_clk_fall) begin
          if (!w_dat_sync) begin
            w_state_next = ST_RELEASE;
          end else begin
            w_state_next = ST_ERR;
            w_err_next   = ERR_NO_ACK;
          end
        end
      end
      ST_RELEASE: begin
        if (w_xfer_to) begin
          w_state_next = ST_ERR;
          w_err_next   = ERR_XFER_TO;
        end else if (w_clk_sync && w_dat_sync) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      ST_ERR: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: line drive. Derived from the state register alone, so an
  // asynchronous reset releases both lines immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    w_clk_low = 1'b0;
    w_dat_low = 1'b0;
    case (r_state)
      ST_INHIBIT: begin
        w_clk_low = 1'b1;
        // Start bit goes out on the last inhibit cycle so DAT is already low
        // when CLK is released.
        w_dat_low = w_inh_last;
      end
      ST_REQ: begin
        w_dat_low = 1'b1;
      end
      ST_BITS: begin
        w_dat_low = r_dat_low;
      end
      default: begin
        w_dat_low = 1'b0;
      end
    endcase
  end

  assign PS2_CLK = w_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = w_dat_low ? 1'b0 : 1'bz;

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign error     = (r_state == ST_ERR);
  assign err_code  = r_err_code;

  // --------------------------------------------------------------------------
  // Datapath: timers, frame shifter, bit counter, error code
  // --------------------------------------------------------------------------
  // The falling edge that ends REQ is the first device clock: it starts the
  // transfer timer and puts data[0] on the wire.
  assign w_first_edge = (r_state == ST_REQ) && (w_state_next == ST_BITS);
  assign w_shift      = w_clk_fall && (w_state_next != ST_ERR) &&
                        ((r_state == ST_REQ) || (r_state == ST_BITS));

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_tmr      <= '0;
      r_xfer     <= '0;
      r_frame    <= '0;
      r_bit      <= '0;
      r_dat_low  <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      // Phase timer for INHIBIT/REQ: cleared on every state change.
      if (w_state_next != r_state) begin
        r_tmr <= '0;
      end else if (r_tmr != c_tmr_max) begin
        r_tmr <= r_tmr + c_tmr_one;
      end

      // Transfer timer spans BITS, ACK and RELEASE as one window.
      if (w_first_edge) begin
        r_xfer <= '0;
      end else if (w_in_xfer && (r_xfer != c_tmr_max)) begin
        r_xfer <= r_xfer + c_tmr_one;
      end

      // Frame layout, LSB first: data[7:0], parity, stop (always 1).
      if (w_accept) begin
        r_frame   <= {1'b1, odd_parity(cmd_data), cmd_data};
        r_dat_low <= 1'b0;
      end else if (w_shift) begin
        r_dat_low <= ~r_frame[0];
        r_frame   <= {1'b1, r_frame[9:1]};
      end

      // r_bit is the frame index currently on the wire (0..9).
      if (w_first_edge) begin
        r_bit <= '0;
      end else if ((r_state == ST_BITS) && w_shift) begin
        r_bit <= r_bit + 4'd1;
      end

      if (w_accept) begin
        r_err_code <= ERR_NONE;
      end else if ((w_state_next == ST_ERR) && (r_state != ST_ERR)) begin
        r_err_code <= w_err_next;
      end
    end
  end

endmodule
`default_nettype wire
